sm4_dec_core: RTL
=================

# sm4_dec_core

Iterative SM4 block decryptor: the receive-side counterpart of the SM4 encryption round datapath (`f`) and key-expansion round (`rk`). It expands a 128-bit key into 32 round keys, stores them, then runs 32 decryption rounds that consume the keys in reverse order (rk31 down to rk0). The block sits between the ciphertext source and the plaintext sink, using a valid/ready handshake on both sides.

## Interface
- No parameters. Block size, key size and round count are fixed by SM4.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset. Synchronous and active-high; one clock, no other clock domains.
- in_valid  in  1  key and ct are valid.
- in_ready  out  1  block can accept a job. Reset value 1.
- key  in  128  MK0..MK3, with MK0 in bits [127:96].
- ct  in  128  ciphertext X0..X3, with X0 in bits [127:96].
- out_valid  out  1  pt is valid. Reset value 0.
- out_ready  in  1  sink accepts pt.
- pt  out  128  plaintext. Reset value 0.
- busy  out  1  high whenever state is not IDLE. Reset value 0.

## Operation
- States:
  - IDLE -> KE_S, on in_valid && in_ready.
  - KE_S <-> KE_U for 32 rounds.
  - KE_U(round 31) -> DE_S.
  - DE_S <-> DE_U for 32 rounds.
  - DE_U(round 31) -> DONE.
  - DONE -> IDLE, on out_valid && out_ready.
- On accept:
  - Latch K = key ^ FK.
  - Latch X = ct.
  - Clear the 5-bit round counter.
- S phase: the shared round unit drives X1^X2^X3^C into the registered S-boxes (4 x 8-bit). The S-box output is available on the next cycle.
- U phase:
  - Apply the linear transform. KE uses L'(B) = B ^ (B<<<13) ^ (B<<<23). DE uses L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
  - Shift the word window: {X1, X2, X3, X0^L}.
  - In KE, write the new word to rk[counter].
  - Increment the counter; it wraps 31 -> 0 at the phase change.
- Constants:
  - C in KE is CK[counter].
  - C in DE is rk[31 - counter].
- DONE:
  - pt = {X35, X34, X33, X32} (reverse transform R).
  - pt is registered and held stable until the handshake.
- Backpressure: out_valid stays high and pt stays frozen while out_ready is 0, for any number of cycles.
- in_ready is high only in IDLE. A new job cannot overlap an unfinished job or an unconsumed output.
- RST in any state:
  - Next state is IDLE, in_ready=1, out_valid=0, busy=0, pt=0.
  - Counter cleared.
  - Key-cache tag invalidated.
  - Round-key RAM contents are don't-care.
- in_valid while busy is ignored. The source must hold key and ct until it sees in_ready.

## Timing
- Accept on edge N. KE occupies cycles N+1..N+64. DE occupies cycles N+65..N+128.
- out_valid first high in cycle N+129. Without cache, latency is 129 cycles from accept to output.
- in_ready rises the cycle after the output handshake edge.
- Sustained throughput: one block per 130 cycles when out_ready is held at 1.

## Configuration
- SM4_KEY_CACHE_EN defined:
  - Keep a 128-bit tag of the last fully expanded key plus a valid bit.
  - On accept with tag valid and key == tag, skip KE: next state is DE_S directly.
  - Latency on a cache hit is 65 cycles.
  - The tag is written only when KE completes round 31. A reset during KE leaves the tag invalid.
- SM4_KEY_CACHE_EN undefined: every job runs KE; no tag registers.

## Structure
- Package `sm4_pkg`:
  - FK0..FK3 constants.
  - CK[0..31] table. CK byte j of word i is (4i+j)*7 mod 256.
  - State enum.
  - Functions `sm4_l` and `sm4_lp`.
- Sub-module `sm4_round_unit`:
  - Four S_BOX instances, XOR front end, mode-selected L/L'.
  - Returns the new word one cycle after its inputs.
- Top level: FSM, counter, 32x32 round-key register file, window registers, optional tag.

## Test plan
- Standard vector: key=0123456789abcdeffedcba9876543210, ct=681edf34d206965e86b3e94f536e4246 -> pt=0123456789abcdeffedcba9876543210, out_valid first high at N+129.
- Round-key check: after KE on the same key, rk[0]=f12186f9 and rk[31]=9124a012.
- Backpressure: out_ready=0 for 20 cycles -> pt and out_valid stable, in_ready=0 throughout. Then out_ready=1 -> in_ready=1 on the following cycle.
- RST asserted at cycle N+40 (mid-KE) -> next cycle in IDLE with outputs at reset values. A rerun of the standard vector passes.
- Back-to-back jobs with the same key (only with SM4_KEY_CACHE_EN defined) -> second job's latency is 65 cycles with correct pt. A different key takes 129 cycles.
- in_valid held high while busy with changing key/ct -> no effect on the result in flight.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 constants, state encoding and word-level transforms for the decryptor.
package sm4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KE_S,
        ST_KE_U,
        ST_DE_S,
        ST_DE_U,
        ST_DONE
    } state_e;

    localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

    localparam logic [0:255][7:0] SBOX = {
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] sm4_l(input logic [31:0] b);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] sm4_lp(input logic [31:0] b);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    // CK byte j of word i is (4i+j)*7 mod 256
    function automatic logic [31:0] sm4_ck(input logic [4:0] i);
        logic [31:0] w;
        logic [31:0] v;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            v = ({27'd0, i} * 32'd4 + 32'(j)) * 32'd7;
            w[8*(3-j) +: 8] = v[7:0];
        end
        return w;
    endfunction

endpackage

// File: rtl/sm4_round_unit.sv
// Shared SM4 round: XOR front end, registered S-box bank, then L (decrypt) or L' (key expansion).
module sm4_round_unit
    import sm4_pkg::*;
(
    input  logic         clk_i,
    input  logic         ke_i,
    input  logic [127:0] win_i,
    input  logic [31:0]  c_i,
    output logic [31:0]  word_o
);

    logic [31:0] a;
    logic [31:0] b_q;

    assign a = win_i[95:64] ^ win_i[63:32] ^ win_i[31:0] ^ c_i;

    always_ff @(posedge clk_i) begin
        for (int g = 0; g < 4; g++) begin
            b_q[8*g +: 8] <= SBOX[a[8*g +: 8]];
        end
    end

    // X0 is unchanged between the S and U cycles, so it can be used directly here
    assign word_o = win_i[127:96] ^ (ke_i ? sm4_lp(b_q) : sm4_l(b_q));

endmodule

// File: rtl/sm4_dec_core.sv
// Iterative SM4 block decryptor: 32 key-expansion rounds, then 32 reversed-key rounds.
// Optional key cache (skip expansion on repeated key) enabled by SM4_KEY_CACHE_EN.
module sm4_dec_core
    import sm4_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic [127:0] ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);

    state_e       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [127:0] k_q, k_d;
    logic [127:0] x_q, x_d;
    logic [127:0] pt_q, pt_d;
    logic [31:0]  rk_q [32];

    logic         ke;
    logic         accept;
    logic         hit;
    logic [127:0] win;
    logic [31:0]  c;
    logic [31:0]  word;

    assign accept = in_valid && (state_q == ST_IDLE);
    assign ke     = (state_q == ST_KE_S) || (state_q == ST_KE_U);
    assign win    = ke ? k_q : x_q;
    assign c      = ke ? sm4_ck(cnt_q) : rk_q[~cnt_q];

    sm4_round_unit u_round (
        .clk_i  (CLK),
        .ke_i   (ke),
        .win_i  (win),
        .c_i    (c),
        .word_o (word)
    );

`ifdef SM4_KEY_CACHE_EN
    logic [127:0] tag_q, tag_d;
    logic         tag_v_q, tag_v_d;

    assign hit = tag_v_q && (key == tag_q);

    // Tag is captured on a miss but only marked valid once expansion finishes
    always_comb begin
        tag_d   = tag_q;
        tag_v_d = tag_v_q;
        if (accept && !hit) begin
            tag_d   = key;
            tag_v_d = 1'b0;
        end
        if (state_q == ST_KE_U && cnt_q == 5'd31) begin
            tag_v_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_q   <= '0;
            tag_v_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            tag_v_q <= tag_v_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        x_d     = x_q;
        pt_d    = pt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    k_d     = key ^ FK;
                    x_d     = ct;
                    cnt_d   = 5'd0;
                    state_d = hit ? ST_DE_S : ST_KE_S;
                end
            end
            ST_KE_S: state_d = ST_KE_U;
            ST_KE_U: begin
                k_d     = {k_q[95:0], word};
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? ST_DE_S : ST_KE_S;
            end
            ST_DE_S: state_d = ST_DE_U;
            ST_DE_U: begin
                x_d     = {x_q[95:0], word};
                cnt_d   = cnt_q + 5'd1;
                state_d = ST_DE_S;
                if (cnt_q == 5'd31) begin
                    pt_d    = {word, x_q[31:0], x_q[63:32], x_q[95:64]};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            k_q     <= '0;
            x_q     <= '0;
            pt_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            x_q     <= x_d;
            pt_q    <= pt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == ST_KE_U) begin
            rk_q[cnt_q] <= word;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign pt        = pt_q;

endmodule
